matrix_scan_rx: RTL
===================

# matrix_scan_rx

Receive-side counterpart of the 8x8 RGB LED matrix scan driver: monitors the row-multiplexed scan bus (row-select word plus active-low red/green/blue column bytes), reassembles the 8 scanned rows into a complete frame image, and exposes it through a registered pixel read port. It sits beside the game core on CLK_div and serves display mirroring, on-board self-test and frame-level checking in simulation. It also flags broken scan sequences and counts complete frames.

## Interface
Parameters:
- ACTIVE_LOW, 1, column data polarity on the scan bus; 1 = a pixel is lit when its bit is 0.
- CNT_W, 8, width of the frame counter.

Ports:
- CLK_div  in  1  scan clock, the same clock that advances the scan driver.
- reset  in  1  asynchronous, active-high.
- scan_comm  in  4  bit 3 is row enable, bits [2:0] are row index.
- scan_r, scan_g, scan_b  in  8 each  column bytes for the enabled row, with bit i = column i.
- rd_row, rd_col  in  3 each  pixel read address.
- rd_rgb  out  3  {r,g,b} of the addressed pixel from the committed frame, always active-high.
- frame_done  out  1  one-cycle pulse when a full frame commits.
- seq_err  out  1  one-cycle pulse on a scan-order violation.
- locked  out  1  high while in CAPTURE.
- frame_cnt  out  CNT_W  number of committed frames, wraps modulo 2^CNT_W.
- frame_changed  out  1  one-cycle pulse with frame_done when the new frame differs from the previous one. See Configuration.

## Operation
- Input stage: at every edge, register scan_comm and the three column bytes. When ACTIVE_LOW=1, invert the column bytes here. All later logic uses the registered copy.
- Storage:
  - shadow buffer, 8 rows x 24 bits, being assembled;
  - frame buffer, 8 rows x 24 bits, committed image.
- FSM states: HUNT and CAPTURE. A 3-bit `expect` register holds the next expected row.
- A registered row with enable=0 is a blank slot. It is ignored: no state, expect or buffer change, and no error.
- HUNT:
  - enabled row 0: write it into shadow row 0, set expect=1, go to CAPTURE;
  - any other enabled row: ignored, no seq_err.
- CAPTURE, enabled row == expect:
  - write the row into the shadow buffer;
  - if expect==7: copy the shadow buffer (including row 7) to the frame buffer, pulse frame_done, increment frame_cnt, set expect=0, stay in CAPTURE;
  - otherwise expect+1.
- CAPTURE, enabled row != expect:
  - pulse seq_err;
  - if the row is 0: restart, write shadow row 0, set expect=1, stay in CAPTURE;
  - otherwise go to HUNT.
  - A repeated row counts as a mismatch.
- A partially assembled frame is never committed, so the frame buffer changes only on a complete in-order 0..7 sequence.
- Reset (any time, including mid-frame):
  - state=HUNT, expect=0;
  - both buffers cleared to all-off;
  - all outputs 0: rd_rgb, frame_done, seq_err, locked, frame_cnt, frame_changed.

## Timing
- A scan word present at edge k is registered at edge k, evaluated by the FSM at edge k+1, and written into the buffers at edge k+1.
- frame_done, seq_err and frame_changed are high for exactly the cycle following edge k+1.
- locked is registered and follows the state.
- rd_rgb has 1-cycle latency: the address sampled at edge n gives data valid after edge n.
- A read at the same edge as a commit returns the old frame (read-before-write).
- frame_cnt wraps from 2^CNT_W−1 to 0, with no saturation.
- Back-to-back frames commit every 8 enabled slots; blank slots stretch the interval but do not break the sequence.

## Configuration
- Macro: MATRIX_SCAN_RX_CHANGE_DET_EN.
- Defined: keep a previous-frame copy (192 bits). On commit, compare the new frame with the previous one. If any bit differs, pulse frame_changed with frame_done. The first frame after reset is compared against all-off.
- Undefined: no previous-frame storage and no comparator. frame_changed stays in the port list, tied to 0.

## Structure
- Shared package `matrix_pkg`: MATRIX_ROWS=8, MATRIX_COLS=8, typedef rgb_row_t (struct of r, g, b, 8 bits each), typedef scan_comm_t (en, row[2:0]), and the scan-FSM state enum.
- One sub-module, `matrix_frame_buf`: 8x24 storage with a row write port and a registered pixel read port. It is instantiated for the frame buffer. The shadow buffer is plain registers in the top module.

## Test plan
- Reset, then scan rows 0..7 with row r having red byte ~(1<<r), green and blue 0xFF → frame_done once after row 7, frame_cnt=1, rd_rgb(r,r)=3'b100, all other pixels 3'b000.
- Start the scan at row 3, rows 3..7 then 0..7 → no seq_err, first frame_done after the second row 7, locked rises at row 0.
- In CAPTURE, send rows 0,1,2,5 → seq_err pulses at row 5, locked drops, frame buffer unchanged, frame_cnt unchanged.
- Send rows 0..3, blank slots with enable=0, then rows 4..7 → a single frame_done with no seq_err. Assert reset after row 4 of the next frame → all outputs 0 and the buffer reads all-off.
- Send 256 identical frames → frame_cnt wraps to 0. With the macro defined, frame_changed pulses only on the first frame. Change one pixel → the next frame_done is accompanied by frame_changed.
- Read pixel (2,5) while the frame commits → old value at that cycle, new value on the next read.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared types for the 8x8 RGB matrix scan receiver: row/scan-word structs and scan FSM states.
package matrix_pkg;

    localparam int unsigned MATRIX_ROWS = 8;
    localparam int unsigned MATRIX_COLS = 8;

    typedef struct packed {
        logic [MATRIX_COLS-1:0] r;
        logic [MATRIX_COLS-1:0] g;
        logic [MATRIX_COLS-1:0] b;
    } rgb_row_t;

    typedef rgb_row_t [MATRIX_ROWS-1:0] frame_t;

    typedef struct packed {
        logic       en;
        logic [2:0] row;
    } scan_comm_t;

    typedef enum logic {
        StHunt,
        StCapture
    } scan_state_e;

    function automatic logic [2:0] pixel_rgb(input rgb_row_t row, input logic [2:0] col);
        return {row.r[col], row.g[col], row.b[col]};
    endfunction

endpackage

// File: rtl/matrix_scan_rx_if.sv
// Row-multiplexed scan bus: row-select word plus raw red/green/blue column bytes.
interface matrix_scan_rx_if;

    logic [3:0] scan_comm;
    logic [7:0] scan_r;
    logic [7:0] scan_g;
    logic [7:0] scan_b;

    modport master (output scan_comm, scan_r, scan_g, scan_b);
    modport slave  (input  scan_comm, scan_r, scan_g, scan_b);

endinterface

// File: rtl/matrix_frame_buf.sv
// 8x24 committed-frame storage: masked row write port and registered pixel read (read-before-write).
module matrix_frame_buf
    import matrix_pkg::*;
(
    input  logic                   CLK_div,
    input  logic                   reset,
    input  logic [MATRIX_ROWS-1:0] wr_mask,
    input  frame_t                 wr_data,
    input  logic [2:0]             rd_row,
    input  logic [2:0]             rd_col,
    output logic [2:0]             rd_rgb
);

    frame_t mem_q;

    always_ff @(posedge CLK_div or posedge reset) begin
        if (reset) begin
            mem_q  <= '0;
            rd_rgb <= '0;
        end else begin
            rd_rgb <= pixel_rgb(mem_q[rd_row], rd_col);
            for (int i = 0; i < MATRIX_ROWS; i++) begin
                if (wr_mask[i]) begin
                    mem_q[i] <= wr_data[i];
                end
            end
        end
    end

endmodule

// File: rtl/matrix_scan_rx.sv
// Scan-bus receiver: reassembles in-order rows 0..7 into a committed frame, flags order errors.
// Optional MATRIX_SCAN_RX_CHANGE_DET_EN adds a previous-frame comparator driving frame_changed.
module matrix_scan_rx
    import matrix_pkg::*;
#(
    parameter int unsigned ACTIVE_LOW = 1,
    parameter int unsigned CNT_W      = 8
) (
    input  logic                CLK_div,
    input  logic                reset,
    matrix_scan_rx_if.slave     scan,
    input  logic [2:0]          rd_row,
    input  logic [2:0]          rd_col,
    output logic [2:0]          rd_rgb,
    output logic                frame_done,
    output logic                seq_err,
    output logic                locked,
    output logic [CNT_W-1:0]    frame_cnt,
    output logic                frame_changed
);

    localparam logic [MATRIX_COLS-1:0] POL_MASK = (ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic [CNT_W-1:0]       CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    scan_comm_t  comm_q;
    rgb_row_t    row_q;
    scan_state_e state_q;
    logic [2:0]  expect_q;
    // Row 7 never lands here: it goes from the input register straight into the commit.
    rgb_row_t [MATRIX_ROWS-2:0] shadow_q;

    logic   row_hit;
    logic   commit;
    frame_t commit_frame;

    always_ff @(posedge CLK_div or posedge reset) begin
        if (reset) begin
            comm_q <= '0;
            row_q  <= '0;
        end else begin
            comm_q  <= scan_comm_t'(scan.scan_comm);
            row_q.r <= scan.scan_r ^ POL_MASK;
            row_q.g <= scan.scan_g ^ POL_MASK;
            row_q.b <= scan.scan_b ^ POL_MASK;
        end
    end

    assign row_hit      = comm_q.en && (comm_q.row == expect_q);
    assign commit       = (state_q == StCapture) && row_hit && (expect_q == 3'd7);
    assign commit_frame = {row_q, shadow_q};

    always_ff @(posedge CLK_div or posedge reset) begin
        if (reset) begin
            state_q    <= StHunt;
            expect_q   <= '0;
            shadow_q   <= '0;
            locked     <= 1'b0;
            frame_done <= 1'b0;
            seq_err    <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            frame_done <= 1'b0;
            seq_err    <= 1'b0;
            if (comm_q.en) begin
                case (state_q)
                    StHunt: begin
                        if (comm_q.row == 3'd0) begin
                            shadow_q[0] <= row_q;
                            expect_q    <= 3'd1;
                            state_q     <= StCapture;
                            locked      <= 1'b1;
                        end
                    end
                    StCapture: begin
                        if (row_hit) begin
                            if (expect_q == 3'd7) begin
                                frame_done <= 1'b1;
                                frame_cnt  <= frame_cnt + CNT_ONE;
                                expect_q   <= 3'd0;
                            end else begin
                                shadow_q[expect_q] <= row_q;
                                expect_q           <= expect_q + 3'd1;
                            end
                        end else begin
                            seq_err <= 1'b1;
                            if (comm_q.row == 3'd0) begin
                                shadow_q[0] <= row_q;
                                expect_q    <= 3'd1;
                            end else begin
                                state_q  <= StHunt;
                                locked   <= 1'b0;
                                expect_q <= 3'd0;
                            end
                        end
                    end
                    default: begin
                        state_q <= StHunt;
                        locked  <= 1'b0;
                    end
                endcase
            end
        end
    end

    matrix_frame_buf u_frame_buf (
        .CLK_div (CLK_div),
        .reset   (reset),
        .wr_mask ({MATRIX_ROWS{commit}}),
        .wr_data (commit_frame),
        .rd_row  (rd_row),
        .rd_col  (rd_col),
        .rd_rgb  (rd_rgb)
    );

`ifdef MATRIX_SCAN_RX_CHANGE_DET_EN
    frame_t prev_q;
    logic   changed_q;

    always_ff @(posedge CLK_div or posedge reset) begin
        if (reset) begin
            prev_q    <= '0;
            changed_q <= 1'b0;
        end else begin
            changed_q <= 1'b0;
            if (commit) begin
                changed_q <= (commit_frame != prev_q);
                prev_q    <= commit_frame;
            end
        end
    end

    assign frame_changed = changed_q;
`else
    assign frame_changed = 1'b0;
`endif

endmodule
